// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The datapath (master) reports hazard sources. The sequencer (slave) returns the stall/flush controls and the perf counters.
interface pipe_hazard_if #(
  parameter int CNT_W = 32
);
  logic             global_en;
  logic [4:0]       id_rf_ra0;
  logic [4:0]       id_rf_ra1;
  logic             id_re0;
  logic             id_re1;
  logic             ex_is_load;
  logic [4:0]       ex_rf_wa;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pipe_en;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output global_en, id_rf_ra0, id_rf_ra1, id_re0, id_re1, ex_is_load, ex_rf_wa,
           ex_br_taken, mem_req, mem_ready,
    input  pipe_en, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  global_en, id_rf_ra0, id_rf_ra1, id_re0, id_re1, ex_is_load, ex_rf_wa,
           ex_br_taken, mem_req, mem_ready,
    output pipe_en, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It handles memory waits first, then taken branches, then load-use bubbles.
// A watchdog on the data-memory wait makes mem_err sticky. Saturating counters track stall cycles and branch flushes.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  state_t           state_r;
  logic [TO_W-1:0]  wait_cnt_r;
  logic             mem_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic pipe_en_s;
  logic raw_hit_s;
  logic mem_wait_s;
  logic br_s;
  logic load_use_s;

  // Hazard detection and priority resolution; everything is gated off while the pipe is disabled
  always_comb begin
    pipe_en_s  = hz.global_en & ~mem_err_r & ~rst;
    raw_hit_s  = hz.ex_is_load & (hz.ex_rf_wa != 5'd0) &
                 ((hz.id_re0 & (hz.id_rf_ra0 == hz.ex_rf_wa)) |
                  (hz.id_re1 & (hz.id_rf_ra1 == hz.ex_rf_wa)));
    mem_wait_s = 1'b0;
    br_s       = 1'b0;
    load_use_s = 1'b0;
    if (pipe_en_s) begin
      case (state_r)
        IDLE:    mem_wait_s = hz.mem_req & ~hz.mem_ready;
        WAIT:    mem_wait_s = ~hz.mem_ready;
        default: mem_wait_s = 1'b0;
      endcase
      // A branch held behind a memory wait fires in the release cycle
      br_s       = hz.ex_br_taken & ~mem_wait_s;
      load_use_s = raw_hit_s & ~mem_wait_s & ~hz.ex_br_taken;
    end else begin
      mem_wait_s = 1'b0;
      br_s       = 1'b0;
      load_use_s = 1'b0;
    end
  end

  assign hz.pipe_en      = pipe_en_s;
  assign hz.pc_stall     = mem_wait_s | load_use_s;
  assign hz.if_id_stall  = mem_wait_s | load_use_s;
  assign hz.if_id_flush  = br_s;
  assign hz.id_ex_stall  = mem_wait_s;
  assign hz.id_ex_flush  = br_s | load_use_s;
  assign hz.ex_mem_stall = mem_wait_s;
  assign hz.mem_wb_flush = mem_wait_s;
  assign hz.mem_err      = mem_err_r;
  assign hz.stall_cnt    = stall_cnt_r;
  assign hz.flush_cnt    = flush_cnt_r;

  // Watchdog FSM and saturating perf counters; all of them freeze while the pipe is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= {TO_W{1'b0}};
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (pipe_en_s) begin
      if ((mem_wait_s | load_use_s) && (stall_cnt_r != CNT_MAX_C)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (br_s && (flush_cnt_r != CNT_MAX_C)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (mem_wait_s) begin
            state_r    <= WAIT;
            wait_cnt_r <= TO_W'(1);
          end
        end
        WAIT: begin
          if (hz.mem_ready) begin
            state_r <= IDLE;
          end else if (wait_cnt_r < TIMEOUT_C) begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
          end else begin
            state_r   <= ERR;
            mem_err_r <= 1'b1;
          end
        end
        ERR:     state_r <= ERR;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4). It runs directed hazard scenarios and then randomized traffic.
// The expected outputs come from a cycle-level reference model. A negedge monitor checks them against the DUT.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic       pe;
    logic [6:0] ctl;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  pipe_hazard_if #(.CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_sc;
  int m_fc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor: outputs are presented every cycle, compared at negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pipe_en", int'(hz.pipe_en), int'(e.pe));
        chk("ctl", int'({hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
                        hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_flush}), int'(e.ctl));
        chk("mem_err", int'(hz.mem_err), int'(e.err));
        chk("stall_cnt", int'(hz.stall_cnt), int'(e.sc));
        chk("flush_cnt", int'(hz.flush_cnt), int'(e.fc));
      end
    end
  end

  // One cycle: apply inputs, predict the response, push it, then advance the model and the clock
  task automatic cyc(input bit r, input bit g, input int a0, input int a1, input bit e0,
                     input bit e1, input bit ld, input int wa, input bit br,
                     input bit rq, input bit rd);
    exp_t e;
    bit pe, mw, bf, lu;
    rst            = r;
    hz.global_en   = g;
    hz.id_rf_ra0   = 5'(a0);
    hz.id_rf_ra1   = 5'(a1);
    hz.id_re0      = e0;
    hz.id_re1      = e1;
    hz.ex_is_load  = ld;
    hz.ex_rf_wa    = 5'(wa);
    hz.ex_br_taken = br;
    hz.mem_req     = rq;
    hz.mem_ready   = rd;

    pe = g && !m_err && !r;
    mw = pe && !rd && (m_wait || rq);
    bf = pe && !mw && br;
    lu = pe && !mw && !br && ld && wa != 0 && ((e0 && a0 == wa) || (e1 && a1 == wa));
    e.pe  = pe;
    e.ctl = {mw | lu, mw | lu, bf, mw, bf | lu, mw, mw};
    e.err = m_err;
    e.sc  = 4'(m_sc);
    e.fc  = 4'(m_fc);
    exp_q.push_back(e);

    if (r) begin
      m_wait = 0; m_wcnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else if (pe) begin
      if ((mw || lu) && m_sc < CNT_MAX) m_sc++;
      if (bf && m_fc < CNT_MAX) m_fc++;
      if (!m_wait) begin
        if (rq && !rd) begin m_wait = 1; m_wcnt = 1; end
      end else if (rd) begin
        m_wait = 0;
      end else if (m_wcnt < TIMEOUT) begin
        m_wcnt++;
      end else begin
        m_wait = 0; m_err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_cyc();
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int wait_budget;
    rst = 1'b1;
    hz.global_en = 1'b0; hz.id_rf_ra0 = 5'd0; hz.id_rf_ra1 = 5'd0;
    hz.id_re0 = 1'b0; hz.id_re1 = 1'b0; hz.ex_is_load = 1'b0; hz.ex_rf_wa = 5'd0;
    hz.ex_br_taken = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then a single load-use bubble
    reset_cyc();
    cyc(0, 1, 5, 1, 1, 1, 1, 5, 0, 0, 0);
    idle();
    chk("t1_stall_cnt", int'(hz.stall_cnt), 1);

    // x0 destination and unread operand never stall
    cyc(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 5, 1, 0, 1, 5, 0, 0, 0);
    chk("t2_stall_cnt", int'(hz.stall_cnt), 1);

    // branch outranks load-use
    cyc(0, 1, 5, 0, 1, 0, 1, 5, 1, 0, 0);
    idle();
    chk("t3_flush_cnt", int'(hz.flush_cnt), 1);

    // three wait cycles with a held branch, released on the fourth
    reset_cyc();
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("t4_stall_cnt", int'(hz.stall_cnt), 3);
    chk("t4_flush_cnt", int'(hz.flush_cnt), 1);
    idle();

    // watchdog expiry, then recovery through reset
    reset_cyc();
    repeat (5) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_mem_err", int'(hz.mem_err), 1);
    repeat (2) cyc(0, 1, 5, 0, 1, 0, 1, 5, 1, 1, 1);
    reset_cyc();
    chk("t5_mem_err_clr", int'(hz.mem_err), 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // counter saturation, then global_en low freezes everything
    repeat (20) cyc(0, 1, 7, 0, 1, 0, 1, 7, 0, 0, 0);
    chk("t6_sat", int'(hz.stall_cnt), CNT_MAX);
    repeat (3) cyc(0, 0, 7, 0, 1, 0, 1, 7, 1, 1, 0);
    chk("t6_frozen", int'(hz.stall_cnt), CNT_MAX);

    // randomized traffic; rare resets keep the watchdog recoverable
    reset_cyc();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 2) == 0), $urandom_range(0, 7), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end

    wait_budget = 10;
    while (exp_q.size() > 0 && wait_budget > 0) begin
      @(posedge clk);
      wait_budget--;
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
